// File: rtl/lvda_adapter.sv
// LVDA data adapter: bit-serial PIO framing, 8-entry register file, console switch sync.
// Optional countdown timer / INTCV interrupt enabled by defining LVDA_INTERRUPT_TIMER_EN.
module lvda_adapter (
    input  logic SIM_CLK,
    input  logic SIM_RST,
    input  logic A1V,
    input  logic A2V,
    input  logic A3V,
    input  logic A4V,
    input  logic A5V,
    input  logic A6V,
    input  logic A7V,
    input  logic A8V,
    input  logic A9V,
    input  logic PIOV,
    input  logic PBVN,
    input  logic WDA,
    input  logic XDA,
    input  logic YDA,
    input  logic ZDA,
    input  logic AI3V,
    input  logic TRSV,
    input  logic G5VN,
    input  logic BO1N,
    input  logic CST,
    input  logic HLT,
    input  logic TE1H,
    output logic DATAV,
    output logic CSTN,
    output logic HALTV,
    output logic INTCV
);

    localparam int unsigned WORD_W   = 26;
    localparam int unsigned SHIFT_W  = WORD_W + 1;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned SEL_W    = 5;

    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(SHIFT_W);
    localparam logic [SEL_W-1:0] SEL_REGS  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_TIMER = SEL_W'(1);

    logic [ADDR_W-1:0] addr_in_c;
    logic              tick_c;
    logic              start_c;
    logic              end_c;
    logic              commit_c;
    logic [WORD_W-1:0] rdata_c;

    logic                 wda_q, wda_d;
    logic                 pbvn_tick_q, pbvn_tick_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 active_q, active_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 pio_q, pio_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [WORD_W-1:0]    regs_q [NUM_REGS];
    logic [WORD_W-1:0]    regs_d [NUM_REGS];
    logic                 datav_q, datav_d;
    logic                 halt_s1_q, halt_s1_d;
    logic                 halt_s2_q, halt_s2_d;
    logic                 cst_s1_q, cst_s1_d;
    logic                 cst_s2_q, cst_s2_d;
`ifdef LVDA_INTERRUPT_TIMER_EN
    logic [WORD_W-1:0]    timer_q, timer_d;
    logic                 intcv_q, intcv_d;
`endif

    // XDA/YDA/ZDA carry no information for this side; shift MSB is only observed via DATAV.
    logic unused_c;
`ifdef LVDA_INTERRUPT_TIMER_EN
    assign unused_c = ^{XDA, YDA, ZDA, shift_q[SHIFT_W-1]};
`else
    assign unused_c = ^{XDA, YDA, ZDA, BO1N, shift_q[SHIFT_W-1]};
`endif

    assign addr_in_c = {A9V, A8V, A7V, A6V, A5V, A4V, A3V, A2V, A1V};

    always_comb begin
        tick_c   = WDA & ~wda_q;
        start_c  = tick_c & ~PBVN & pbvn_tick_q;
        end_c    = tick_c & active_q & (cnt_q == '0);
        commit_c = end_c & pio_q & addr_q[ADDR_W-1] & TRSV;

        // Read data for an input op is taken from the live address lines at frame start.
        rdata_c = '0;
        if (addr_in_c[7:3] == SEL_REGS) begin
            rdata_c = regs_q[addr_in_c[2:0]];
        end
`ifdef LVDA_INTERRUPT_TIMER_EN
        else if (addr_in_c[7:3] == SEL_TIMER) begin
            rdata_c = timer_q;
        end
`endif

        wda_d       = WDA;
        pbvn_tick_d = tick_c ? PBVN : pbvn_tick_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        addr_d      = addr_q;
        pio_d       = pio_q;
        shift_d     = shift_q;
        regs_d      = regs_q;

        if (end_c) begin
            active_d = 1'b0;
        end
        if (commit_c && (addr_q[7:3] == SEL_REGS)) begin
            regs_d[addr_q[2:0]] = shift_q[WORD_W-1:0];
        end

        // A new frame marker always restarts framing, abandoning any frame in flight.
        if (start_c) begin
            addr_d   = addr_in_c;
            pio_d    = PIOV;
            cnt_d    = FRAME_LEN;
            active_d = 1'b1;
            shift_d  = addr_in_c[ADDR_W-1] ? '0 : {rdata_c, 1'b0};
        end else if (tick_c && active_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q < FRAME_LEN) begin
                shift_d = {shift_q[SHIFT_W-2:0], addr_q[ADDR_W-1] & AI3V};
            end
        end

`ifdef LVDA_INTERRUPT_TIMER_EN
        timer_d = timer_q;
        intcv_d = intcv_q;
        if (commit_c && (addr_q[7:3] == SEL_TIMER)) begin
            timer_d = shift_q[WORD_W-1:0];
        end else if (tick_c && (timer_q != '0)) begin
            timer_d = timer_q - WORD_W'(1);
            if (timer_q == WORD_W'(1)) begin
                intcv_d = 1'b1;
            end
        end
        if (!BO1N) begin
            intcv_d = 1'b0;
        end
`endif

        datav_d   = G5VN ? 1'b0 : (TE1H ? AI3V : shift_d[SHIFT_W-1]);
        halt_s1_d = HLT;
        halt_s2_d = halt_s1_q;
        cst_s1_d  = ~CST;
        cst_s2_d  = cst_s1_q;
    end

    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            wda_q       <= 1'b0;
            pbvn_tick_q <= 1'b1;
            cnt_q       <= '0;
            active_q    <= 1'b0;
            addr_q      <= '0;
            pio_q       <= 1'b0;
            shift_q     <= '0;
            regs_q      <= '{default: '0};
            datav_q     <= 1'b0;
            halt_s1_q   <= 1'b1;
            halt_s2_q   <= 1'b1;
            cst_s1_q    <= 1'b1;
            cst_s2_q    <= 1'b1;
`ifdef LVDA_INTERRUPT_TIMER_EN
            timer_q     <= '0;
            intcv_q     <= 1'b0;
`endif
        end else begin
            wda_q       <= wda_d;
            pbvn_tick_q <= pbvn_tick_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            addr_q      <= addr_d;
            pio_q       <= pio_d;
            shift_q     <= shift_d;
            regs_q      <= regs_d;
            datav_q     <= datav_d;
            halt_s1_q   <= halt_s1_d;
            halt_s2_q   <= halt_s2_d;
            cst_s1_q    <= cst_s1_d;
            cst_s2_q    <= cst_s2_d;
`ifdef LVDA_INTERRUPT_TIMER_EN
            timer_q     <= timer_d;
            intcv_q     <= intcv_d;
`endif
        end
    end

    assign DATAV = datav_q;
    assign HALTV = halt_s2_q;
    assign CSTN  = cst_s2_q;
`ifdef LVDA_INTERRUPT_TIMER_EN
    assign INTCV = intcv_q;
`else
    assign INTCV = 1'b0;
`endif

endmodule

// File: tb/tb_lvda_adapter.sv
// Directed bench for lvda_adapter: reset/sync, PIO write/read framing, timer, gating, abort.
module tb_lvda_adapter;

    logic SIM_CLK = 1'b0;
    logic SIM_RST;
    logic A1V, A2V, A3V, A4V, A5V, A6V, A7V, A8V, A9V;
    logic PIOV, PBVN, WDA, XDA, YDA, ZDA, AI3V, TRSV, G5VN, BO1N, CST, HLT, TE1H;
    logic DATAV, CSTN, HALTV, INTCV;
    logic [8:0] addr_tb;

    int n_cmp = 0;
    int n_err = 0;

    assign {A9V, A8V, A7V, A6V, A5V, A4V, A3V, A2V, A1V} = addr_tb;

    always #5 SIM_CLK = ~SIM_CLK;

    lvda_adapter dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
        .A1V(A1V), .A2V(A2V), .A3V(A3V), .A4V(A4V), .A5V(A5V),
        .A6V(A6V), .A7V(A7V), .A8V(A8V), .A9V(A9V),
        .PIOV(PIOV), .PBVN(PBVN), .WDA(WDA), .XDA(XDA), .YDA(YDA), .ZDA(ZDA),
        .AI3V(AI3V), .TRSV(TRSV), .G5VN(G5VN), .BO1N(BO1N),
        .CST(CST), .HLT(HLT), .TE1H(TE1H),
        .DATAV(DATAV), .CSTN(CSTN), .HALTV(HALTV), .INTCV(INTCV)
    );

    // One WDA bit tick: strobe high for one clock, low for one; returns on a falling edge.
    task automatic bit_tick(input logic pbvn, input logic ai);
        WDA  = 1'b1;
        PBVN = pbvn;
        AI3V = ai;
        @(negedge SIM_CLK);
        WDA  = 1'b0;
        @(negedge SIM_CLK);
    endtask

    // Full frame: start tick, idle tick, 26 shift ticks, commit tick. Captures DATAV per bit.
    task automatic do_frame(input logic [8:0] a, input logic pio, input logic trs,
                            input logic [25:0] w, input int abort_k, output logic [25:0] cap);
        addr_tb = a;
        PIOV    = pio;
        TRSV    = trs;
        cap     = '0;
        bit_tick(1'b0, 1'b0);
        cap[25] = DATAV;
        bit_tick(1'b1, 1'b0);
        for (int k = 1; k <= 26; k++) begin
            if (k == abort_k) return;
            bit_tick(1'b1, w[26-k]);
            if (k <= 25) cap[25-k] = DATAV;
        end
        bit_tick(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        SIM_RST = 1'b0;
        HLT = 1'b1;
        CST = 1'b0;
        repeat (3) @(negedge SIM_CLK);
        n_cmp++; if (HALTV !== 1'b1) begin n_err++; $display("FAIL rst_haltv got=%b exp=1", HALTV); end
        n_cmp++; if (CSTN !== 1'b1) begin n_err++; $display("FAIL rst_cstn got=%b exp=1", CSTN); end
        n_cmp++; if (INTCV !== 1'b0) begin n_err++; $display("FAIL rst_intcv got=%b exp=0", INTCV); end
        n_cmp++; if (DATAV !== 1'b0) begin n_err++; $display("FAIL rst_datav got=%b exp=0", DATAV); end
        SIM_RST = 1'b1;
        HLT = 1'b0;
        CST = 1'b1;
        @(negedge SIM_CLK);
        n_cmp++; if (HALTV !== 1'b1) begin n_err++; $display("FAIL sync1_haltv got=%b exp=1", HALTV); end
        n_cmp++; if (CSTN !== 1'b1) begin n_err++; $display("FAIL sync1_cstn got=%b exp=1", CSTN); end
        @(negedge SIM_CLK);
        n_cmp++; if (HALTV !== 1'b0) begin n_err++; $display("FAIL sync2_haltv got=%b exp=0", HALTV); end
        n_cmp++; if (CSTN !== 1'b0) begin n_err++; $display("FAIL sync2_cstn got=%b exp=0", CSTN); end
        CST = 1'b0;
        repeat (2) @(negedge SIM_CLK);
        n_cmp++; if (CSTN !== 1'b1) begin n_err++; $display("FAIL cst_release got=%b exp=1", CSTN); end
    endtask

    task automatic test_write_read();
        logic [25:0] cap;
        logic [25:0] exp_w;
        exp_w = 26'h2AAAAAA;
        do_frame(9'h103, 1'b1, 1'b1, exp_w, -1, cap);
        do_frame(9'h003, 1'b1, 1'b0, 26'h0, -1, cap);
        for (int i = 25; i >= 0; i--) begin
            n_cmp++;
            if (cap[i] !== exp_w[i]) begin
                n_err++; $display("FAIL rd_reg3_bit%0d got=%b exp=%b", i, cap[i], exp_w[i]);
            end
        end
        do_frame(9'h100, 1'b1, 1'b1, 26'h3FFFFFF, -1, cap);
        do_frame(9'h107, 1'b1, 1'b1, 26'h1234567, -1, cap);
        do_frame(9'h000, 1'b1, 1'b0, 26'h0, -1, cap);
        n_cmp++; if (cap !== 26'h3FFFFFF) begin n_err++; $display("FAIL rd_reg0 got=%h exp=3ffffff", cap); end
        do_frame(9'h007, 1'b1, 1'b0, 26'h0, -1, cap);
        n_cmp++; if (cap !== 26'h1234567) begin n_err++; $display("FAIL rd_reg7 got=%h exp=1234567", cap); end
    endtask

    task automatic test_discard();
        logic [25:0] cap;
        do_frame(9'h105, 1'b1, 1'b0, 26'h1555555, -1, cap);
        do_frame(9'h005, 1'b1, 1'b0, 26'h0, -1, cap);
        n_cmp++; if (cap !== 26'h0) begin n_err++; $display("FAIL trsv_low_reg5 got=%h exp=0000000", cap); end
        do_frame(9'h150, 1'b1, 1'b1, 26'h0ABCDEF, -1, cap);
        do_frame(9'h050, 1'b1, 1'b0, 26'h0, -1, cap);
        n_cmp++; if (cap !== 26'h0) begin n_err++; $display("FAIL bad_addr_read got=%h exp=0000000", cap); end
        do_frame(9'h000, 1'b1, 1'b0, 26'h0, -1, cap);
        n_cmp++; if (cap !== 26'h3FFFFFF) begin n_err++; $display("FAIL bad_addr_alias got=%h exp=3ffffff", cap); end
    endtask

    task automatic test_timer();
        logic [25:0] cap;
        do_frame(9'h108, 1'b1, 1'b1, 26'd3, -1, cap);
`ifdef LVDA_INTERRUPT_TIMER_EN
        bit_tick(1'b1, 1'b0);
        n_cmp++; if (INTCV !== 1'b0) begin n_err++; $display("FAIL tmr_tick1 got=%b exp=0", INTCV); end
        bit_tick(1'b1, 1'b0);
        n_cmp++; if (INTCV !== 1'b0) begin n_err++; $display("FAIL tmr_tick2 got=%b exp=0", INTCV); end
        bit_tick(1'b1, 1'b0);
        n_cmp++; if (INTCV !== 1'b1) begin n_err++; $display("FAIL tmr_tick3 got=%b exp=1", INTCV); end
        bit_tick(1'b1, 1'b0);
        n_cmp++; if (INTCV !== 1'b1) begin n_err++; $display("FAIL tmr_hold got=%b exp=1", INTCV); end
        BO1N = 1'b0;
        @(negedge SIM_CLK);
        BO1N = 1'b1;
        n_cmp++; if (INTCV !== 1'b0) begin n_err++; $display("FAIL tmr_ack got=%b exp=0", INTCV); end
`else
        repeat (4) bit_tick(1'b1, 1'b0);
        n_cmp++; if (INTCV !== 1'b0) begin n_err++; $display("FAIL notmr_intcv got=%b exp=0", INTCV); end
        do_frame(9'h008, 1'b1, 1'b0, 26'h0, -1, cap);
        n_cmp++; if (cap !== 26'h0) begin n_err++; $display("FAIL notmr_read got=%h exp=0000000", cap); end
        BO1N = 1'b0;
        @(negedge SIM_CLK);
        BO1N = 1'b1;
        n_cmp++; if (INTCV !== 1'b0) begin n_err++; $display("FAIL notmr_ack got=%b exp=0", INTCV); end
`endif
    endtask

    task automatic test_gating();
        logic [25:0] cap;
        logic [3:0]  pat;
        G5VN = 1'b1;
        do_frame(9'h003, 1'b1, 1'b0, 26'h0, -1, cap);
        n_cmp++; if (cap !== 26'h0) begin n_err++; $display("FAIL gated_datav got=%h exp=0000000", cap); end
        G5VN = 1'b0;
        TE1H = 1'b1;
        pat  = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            AI3V = pat[i];
            @(negedge SIM_CLK);
            n_cmp++;
            if (DATAV !== pat[i]) begin n_err++; $display("FAIL loopback%0d got=%b exp=%b", i, DATAV, pat[i]); end
        end
        TE1H = 1'b0;
        AI3V = 1'b0;
        @(negedge SIM_CLK);
    endtask

    task automatic test_abort();
        logic [25:0] cap;
        do_frame(9'h102, 1'b1, 1'b1, 26'h0F0F0F0, -1, cap);
        // Abort when the counter reads 10 (after 16 shifts) by starting a read of the same reg.
        do_frame(9'h102, 1'b1, 1'b1, 26'h3333333, 17, cap);
        do_frame(9'h002, 1'b1, 1'b0, 26'h0, -1, cap);
        n_cmp++; if (cap !== 26'h0F0F0F0) begin n_err++; $display("FAIL abort_keep got=%h exp=0f0f0f0", cap); end
        do_frame(9'h002, 1'b1, 1'b0, 26'h0, -1, cap);
        n_cmp++; if (cap !== 26'h0F0F0F0) begin n_err++; $display("FAIL abort_reread got=%h exp=0f0f0f0", cap); end
    endtask

    initial begin
        SIM_RST = 1'b0;
        addr_tb = '0;
        PIOV = 1'b0; PBVN = 1'b1; WDA = 1'b0;
        XDA = 1'b0; YDA = 1'b0; ZDA = 1'b0;
        AI3V = 1'b0; TRSV = 1'b0; G5VN = 1'b0; BO1N = 1'b1;
        CST = 1'b0; HLT = 1'b1; TE1H = 1'b0;
        @(negedge SIM_CLK);
        test_reset();
        test_write_read();
        test_discard();
        test_timer();
        test_gating();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
